// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
// Contents: hazState_t (RUN, MCWAIT), forward-select codes FWD_RF/FWD_M/FWD_W,
// and the default ResultSrc encoding that marks a load.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MCWAIT = 1'b1
    } hazState_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    localparam logic [1:0] LOAD_SRC_DEFAULT = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_fwd_sel.sv
// rtl/pipeline_hazard_ctrl_hazard_fwd_sel.sv - per-operand producer compare
// Ports:
//   rs             in  5  consuming source register
//   rdNear, weNear in  5/1 younger producer (wins on a double match)
//   rdFar,  weFar  in  5/1 older producer
//   sel            out 2  FWD_M on near match, FWD_W on far match, else FWD_RF
// x0 never matches, so it can neither forward nor stall.
module hazard_fwd_sel
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rdNear,
    input  logic       weNear,
    input  logic [4:0] rdFar,
    input  logic       weFar,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (weFar && (rdFar != 5'd0) && (rdFar == rs)) begin
            sel = FWD_W;
        end
        if (weNear && (rdNear != 5'd0) && (rdNear == rs)) begin
            sel = FWD_M;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward control for a 5-stage pipeline
// Macro HAZARD_FWD_EN: defined -> M/W forwarding to E; undefined -> no forwarding,
// decode stalls on any E/M producer match.
// Parameters: MC_LAT (multicycle E occupancy, 2..15), LOAD_SRC (ResultSrc load code).
// Ports:
//   clk, rst                      clock, async active-high reset
//   Rs1D, Rs2D                    decode sources
//   Rs1E, Rs2E, RdE               execute sources/destination
//   RdM, RdW                      memory/writeback destinations
//   RegWriteE/M/W                 per-stage write enables
//   ResultSrcE, PCSrcE, McStartE  execute result select, redirect, multicycle start
//   StallF, StallD, FlushD, FlushE  pipeline register control (combinational)
//   ForwardAE, ForwardBE          ALU operand select
//   McBusy                        multicycle op in progress
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int         MC_LAT   = 4,
    parameter logic [1:0] LOAD_SRC = LOAD_SRC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] ResultSrcE,
    input  logic [1:0] PCSrcE,
    input  logic       McStartE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       McBusy
);

    hazState_t  state;
    logic [3:0] cnt;

    logic inRun;
    logic mcWait;
    logic redirect;
    logic loadUse;
    logic dataStall;
    logic [1:0] selA;
    logic [1:0] selB;

    assign inRun    = (state == RUN);
    assign mcWait   = (state == MCWAIT);
    // An unresolved multicycle op in E cannot redirect, so PCSrcE only counts in RUN.
    assign redirect = inRun && (PCSrcE != 2'b00);
    assign loadUse  = inRun && (ResultSrcE == LOAD_SRC) && RegWriteE && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // The start cycle is part of the occupancy, so MCWAIT lasts MC_LAT-1 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (McStartE && (PCSrcE == 2'b00)) begin
                        state <= MCWAIT;
                        cnt   <= 4'(MC_LAT - 1);
                    end
                end
                MCWAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_FWD_EN
    hazard_fwd_sel fwdSelA (
        .rs(Rs1E), .rdNear(RdM), .weNear(RegWriteM), .rdFar(RdW), .weFar(RegWriteW), .sel(selA)
    );
    hazard_fwd_sel fwdSelB (
        .rs(Rs2E), .rdNear(RdM), .weNear(RegWriteM), .rdFar(RdW), .weFar(RegWriteW), .sel(selB)
    );

    assign dataStall = loadUse;
    assign ForwardAE = rst ? FWD_RF : selA;
    assign ForwardBE = rst ? FWD_RF : selB;
`else
    // Without forwarding the same compare runs in Decode against E and M producers.
    // W is left out: the register file writes before it reads.
    hazard_fwd_sel stallSelA (
        .rs(Rs1D), .rdNear(RdE), .weNear(RegWriteE), .rdFar(RdM), .weFar(RegWriteM), .sel(selA)
    );
    hazard_fwd_sel stallSelB (
        .rs(Rs2D), .rdNear(RdE), .weNear(RegWriteE), .rdFar(RdM), .weFar(RegWriteM), .sel(selB)
    );

    logic unusedNoFwd;
    assign unusedNoFwd = ^{Rs1E, Rs2E, RdW, RegWriteW};

    assign dataStall = loadUse || (inRun && ((selA != FWD_RF) || (selB != FWD_RF)));
    assign ForwardAE = FWD_RF;
    assign ForwardBE = FWD_RF;
`endif

    // Redirect wins: the stalled instruction is on the wrong path anyway.
    assign StallF = !rst && (mcWait || (!redirect && dataStall));
    assign StallD = StallF;
    assign FlushD = !rst && redirect;
    assign FlushE = !rst && (redirect || dataStall);
    assign McBusy = !rst && mcWait;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE, PCSrcE;
    logic       McStartE;
    logic       StallF, StallD, FlushD, FlushE, McBusy;
    logic [1:0] ForwardAE, ForwardBE;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {StallF, StallD, FlushD, FlushE, McBusy, ForwardAE, ForwardBE}
    localparam logic [8:0] E_IDLE  = 9'b00000_00_00;
    localparam logic [8:0] E_STALL = 9'b11010_00_00;
    localparam logic [8:0] E_MC    = 9'b11001_00_00;
    localparam logic [8:0] E_REDIR = 9'b00110_00_00;
    localparam logic [8:0] E_FA_M  = 9'b00000_10_00;
    localparam logic [8:0] E_FA_W  = 9'b00000_01_00;
    localparam logic [8:0] E_FB_M  = 9'b00000_00_10;

    typedef struct {
        string      tag;
        logic [8:0] val;
    } expItem_t;

    expItem_t sbQueue[$];
    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(.MC_LAT(4), .LOAD_SRC(2'b01)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McStartE(McStartE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McBusy(McBusy)
    );

    always #5 clk = ~clk;

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        ResultSrcE = 2'b00; PCSrcE = 2'b00; McStartE = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [8:0] val);
        expItem_t it;
        logic [8:0] obs;
        it.tag = tag;
        it.val = val;
        sbQueue.push_back(it);
        @(negedge clk);
        it = sbQueue.pop_front();
        obs = {StallF, StallD, FlushD, FlushE, McBusy, ForwardAE, ForwardBE};
        checks++;
        assert (obs === it.val) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", it.tag, obs, it.val);
        end
    endtask

    task automatic load_use(input logic [4:0] rd);
        RdE = rd; ResultSrcE = 2'b01; RegWriteE = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        load_use(5); Rs1D = 5;
        expect_out("reset_forces_zero", E_IDLE);
        cyc(); rst = 0; idle();
        expect_out("idle_after_reset", E_IDLE);

        cyc(); load_use(5); Rs1D = 5;
        expect_out("load_use_rs1", E_STALL);
        cyc(); idle();
        expect_out("load_use_released", E_IDLE);
        cyc(); load_use(9); Rs2D = 9;
        expect_out("load_use_rs2", E_STALL);
        cyc(); idle(); load_use(0); Rs1D = 0;
        expect_out("load_x0_no_stall", E_IDLE);
        cyc(); idle(); load_use(5); RegWriteE = 0; Rs1D = 5;
        expect_out("load_no_we_no_stall", E_IDLE);
        cyc(); idle(); RdE = 6; RegWriteE = 1; Rs1D = 6;
        expect_out("alu_e_match", FWD ? E_IDLE : E_STALL);

        cyc(); idle(); RdM = 3; RegWriteM = 1; Rs2D = 3;
        expect_out("m_match_decode", FWD ? E_IDLE : E_STALL);
        cyc(); idle();
        expect_out("m_match_released", E_IDLE);
        cyc(); idle(); RdE = 0; RegWriteE = 1; Rs1D = 0;
        expect_out("e_x0_no_stall", E_IDLE);
        cyc(); idle(); RdW = 4; RegWriteW = 1; Rs1D = 4;
        expect_out("w_match_no_stall", E_IDLE);

        cyc(); idle(); RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7;
        expect_out("fwd_a_m_wins", FWD ? E_FA_M : E_IDLE);
        cyc(); RegWriteM = 0;
        expect_out("fwd_a_from_w", FWD ? E_FA_W : E_IDLE);
        cyc(); idle(); RdM = 8; RegWriteM = 1; Rs2E = 8;
        expect_out("fwd_b_from_m", FWD ? E_FB_M : E_IDLE);
        cyc(); idle(); RdM = 0; RdW = 0; RegWriteM = 1; RegWriteW = 1;
        expect_out("fwd_x0_none", E_IDLE);

        cyc(); idle(); McStartE = 1;
        expect_out("mc_start_cycle", E_IDLE);
        cyc(); idle(); load_use(5); Rs1D = 5;
        expect_out("mc_wait_1_no_flush", E_MC);
        cyc(); idle(); PCSrcE = 2'b01;
        expect_out("mc_wait_2_redirect_ignored", E_MC);
        cyc(); idle(); McStartE = 1;
        expect_out("mc_wait_3_start_ignored", E_MC);
        cyc(); idle();
        expect_out("mc_back_to_run", E_IDLE);
        cyc(); idle();
        expect_out("mc_stays_run", E_IDLE);

        cyc(); idle(); PCSrcE = 2'b01; McStartE = 1; load_use(5); Rs1D = 5;
        expect_out("redirect_priority", E_REDIR);
        cyc(); idle();
        expect_out("redirect_no_mcwait", E_IDLE);

        cyc(); idle(); McStartE = 1;
        expect_out("rst_test_start", E_IDLE);
        cyc(); idle();
        expect_out("rst_test_cnt3", E_MC);
        cyc(); rst = 1; load_use(5); Rs1D = 5;
        expect_out("rst_in_mcwait", E_IDLE);
        cyc(); rst = 0; idle();
        expect_out("rst_release_run", E_IDLE);
        cyc(); idle();
        expect_out("rst_no_residual", E_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
